// File: rtl/seg_monitor.sv
// seg_monitor: glitch-filtered 7-segment bus checker that decodes each
// stable pattern to BCD and flags illegal patterns and out-of-order digits.
module seg_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg,
    input  logic             clr,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             new_digit,
    output logic             bad_pattern,
    output logic             seq_err,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_e;

    localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [6:0]       seg_q;
    logic [6:0]       last_pat_q;
    logic [3:0]       stab_q;
    logic [3:0]       digit_q;
    logic             valid_q;
    logic             new_q;
    logic             bad_q;
    logic             seq_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] err_q;

    logic             commit;
    logic             dec_ok;
    logic [3:0]       dec_val;
    logic [3:0]       expect_d;
    logic             seq_bad;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] err_d;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        unique case (seg_q)
            7'h3F: dec_val = 4'd0;
            7'h06: dec_val = 4'd1;
            7'h5B: dec_val = 4'd2;
            7'h4F: dec_val = 4'd3;
            7'h66: dec_val = 4'd4;
            7'h6D: dec_val = 4'd5;
            7'h7D: dec_val = 4'd6;
            7'h07: dec_val = 4'd7;
            7'h7F: dec_val = 4'd8;
            7'h6F: dec_val = 4'd9;
            default: dec_ok = 1'b0;
        endcase
    end

    // Commit fires once per stable run, on the edge stab reaches the window.
    always_comb begin
        commit   = (seg == seg_q) && (stab_q == STAB_MAX - 4'd1)
                   && (seg_q != last_pat_q);
        expect_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        seq_bad  = (state_q == TRACK) && (dec_val != expect_d);
        acc_d    = (&acc_q) ? acc_q : acc_q + CNT_ONE;
        err_d    = (&err_q) ? err_q : err_q + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            seg_q      <= 7'h00;
            last_pat_q <= 7'h00;
            stab_q     <= 4'd0;
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            new_q      <= 1'b0;
            bad_q      <= 1'b0;
            seq_q      <= 1'b0;
            acc_q      <= '0;
            err_q      <= '0;
        end else if (clr) begin
            state_q    <= IDLE;
            last_pat_q <= 7'h00;
            stab_q     <= 4'd0;
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            new_q      <= 1'b0;
            bad_q      <= 1'b0;
            seq_q      <= 1'b0;
            acc_q      <= '0;
            err_q      <= '0;
        end else begin
            new_q <= 1'b0;
            bad_q <= 1'b0;
            seq_q <= 1'b0;
            if (seg != seg_q) begin
                seg_q  <= seg;
                stab_q <= 4'd1;
            end else if (stab_q != STAB_MAX) begin
                stab_q <= stab_q + 4'd1;
            end
            if (commit) begin
                last_pat_q <= seg_q;
                if (!dec_ok) begin
                    bad_q   <= 1'b1;
                    state_q <= FAULT;
                    valid_q <= 1'b0;
                    err_q   <= err_d;
                end else begin
                    new_q   <= 1'b1;
                    digit_q <= dec_val;
                    state_q <= TRACK;
                    valid_q <= 1'b1;
                    acc_q   <= acc_d;
                    if (seq_bad) begin
                        seq_q <= 1'b1;
                        err_q <= err_d;
                    end
                end
            end
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign new_digit   = new_q;
    assign bad_pattern = bad_q;
    assign seq_err     = seq_q;
    assign accept_cnt  = acc_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_seg_monitor.sv
// tb_seg_monitor: directed plus random stimulus against a run-length
// reference model; two instances differ only in counter width.
module tb_seg_monitor;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [6:0]  seg = 7'h00;

    logic [3:0]  digit, digit2;
    logic        dv, dv2, nd, nd2, bad, bad2, sq, sq2;
    logic [15:0] acc, err;
    logic [1:0]  acc2, err2;

    seg_monitor #(.STABLE_CYCLES(S), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .seg(seg), .clr(clr),
        .digit(digit), .digit_valid(dv), .new_digit(nd),
        .bad_pattern(bad), .seq_err(sq),
        .accept_cnt(acc), .err_cnt(err)
    );

    seg_monitor #(.STABLE_CYCLES(S), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .seg(seg), .clr(clr),
        .digit(digit2), .digit_valid(dv2), .new_digit(nd2),
        .bad_pattern(bad2), .seq_err(sq2),
        .accept_cnt(acc2), .err_cnt(err2)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Model: run length of the current sample, last committed pattern,
    // whether a digit is being tracked, and plain event totals.
    int m_cur, m_run, m_last, m_digit, m_acc, m_err;
    bit m_track, m_nd, m_bad, m_sq;

    function automatic int decode(int p);
        for (int i = 0; i < 10; i++)
            if (int'(pats[i]) == p) return i;
        return -1;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_cur = 0; m_run = 0; m_last = 0; m_digit = 0;
        m_acc = 0; m_err = 0; m_track = 0;
        m_nd = 0; m_bad = 0; m_sq = 0;
    endtask

    task automatic model_edge();
        int d;
        m_nd = 0; m_bad = 0; m_sq = 0;
        if (rst) begin
            model_reset();
        end else if (clr) begin
            m_run = 0; m_last = 0; m_digit = 0;
            m_acc = 0; m_err = 0; m_track = 0;
        end else if (int'(seg) != m_cur) begin
            m_cur = int'(seg);
            m_run = 1;
        end else if (m_run < S) begin
            m_run++;
            if (m_run == S && m_cur != m_last) begin
                m_last = m_cur;
                d = decode(m_cur);
                if (d < 0) begin
                    m_bad = 1; m_err++; m_track = 0;
                end else begin
                    m_nd = 1; m_acc++;
                    if (m_track && d != (m_digit + 1) % 10) begin
                        m_sq = 1; m_err++;
                    end
                    m_digit = d; m_track = 1;
                end
            end
        end
    endtask

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("digit", digit, m_digit);
        chk("digit_valid", dv, int'(m_track));
        chk("new_digit", nd, int'(m_nd));
        chk("bad_pattern", bad, int'(m_bad));
        chk("seq_err", sq, int'(m_sq));
        chk("accept_cnt", acc, sat(m_acc, 65535));
        chk("err_cnt", err, sat(m_err, 65535));
        chk("digit_w2", digit2, m_digit);
        chk("valid_w2", dv2, int'(m_track));
        chk("new_w2", nd2, int'(m_nd));
        chk("bad_w2", bad2, int'(m_bad));
        chk("seq_w2", sq2, int'(m_sq));
        chk("accept_cnt_w2", acc2, sat(m_acc, 3));
        chk("err_cnt_w2", err2, sat(m_err, 3));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    int pulses;

    task automatic hold(logic [6:0] p, int n);
        seg = p;
        repeat (n) begin
            step();
            pulses += int'(nd) + int'(bad) + int'(sq);
        end
    endtask

    initial begin
        int p;
        int n;
        model_reset();
        repeat (2) step();
        chk("reset_digit", digit, 0);
        chk("reset_valid", dv, 0);
        chk("reset_acc", acc, 0);
        rst = 1'b0;

        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            seg = pats[i % 10];
            for (int c = 0; c < 10; c++) begin
                step();
                pulses += int'(nd);
                if (c == S - 1) chk("nd_latency", nd, 1);
            end
        end
        chk("count_pulses", pulses, 11);
        chk("count_acc", acc, 11);
        chk("count_err", err, 0);
        chk("count_digit", digit, 0);

        hold(7'h06, 10);
        pulses = 0;
        hold(7'h7F, 3);
        hold(7'h06, 10);
        chk("glitch_pulses", pulses, 0);
        chk("glitch_digit", digit, 1);

        hold(7'h5B, 10);
        hold(7'h66, S);
        chk("skip_nd", nd, 1);
        chk("skip_seq", sq, 1);
        chk("skip_digit", digit, 4);
        chk("skip_err", err, 1);
        hold(7'h66, 6);

        hold(7'h49, S);
        chk("illegal_bad", bad, 1);
        chk("illegal_valid", dv, 0);
        chk("illegal_digit", digit, 4);
        hold(7'h49, 6);
        hold(7'h6D, S);
        chk("resync_nd", nd, 1);
        chk("resync_seq", sq, 0);
        chk("resync_valid", dv, 1);
        chk("resync_acc", acc, 15);
        hold(7'h6D, 6);

        seg = 7'h4F;
        repeat (S - 1) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_nd", nd, 0);
        chk("clr_acc", acc, 0);
        chk("clr_err", err, 0);
        repeat (S - 1) step();
        chk("clr_early", nd, 0);
        step();
        chk("clr_recommit", nd, 1);
        chk("clr_digit", digit, 3);

        for (int i = 0; i < 5; i++)
            hold((i % 2 == 0) ? 7'h49 : 7'h12, 6);
        chk("sat_err_w2", err2, 3);
        chk("sat_err_w16", err, 5);

        hold(7'h06, S);
        chk("rst_pre_nd", nd, 1);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_nd", nd, 0);
        chk("rst_digit", digit, 0);
        chk("rst_err", err, 0);
        step();
        rst = 1'b0;

        for (int b = 0; b < 300; b++) begin
            n = $urandom_range(0, 9);
            if (n < 6) p = int'(pats[(m_digit + 1) % 10]);
            else if (n < 8) p = int'(pats[$urandom_range(0, 9)]);
            else p = int'($urandom_range(0, 127));
            seg = 7'(p);
            n = $urandom_range(1, 8);
            for (int c = 0; c < n; c++) begin
                clr = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 299) == 0) begin
                    rst = 1'b1;
                    #1;
                    model_reset();
                    check_all();
                end
                step();
                rst = 1'b0;
                clr = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
